multicycle_control: RTL

- Main control FSM for the multicycle variant of the MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath mux/enable, including the 2-bit alu_op consumed by alu_control.
- Memory accesses use a ready handshake, so the same controller runs against single-cycle SRAM or wait-stated memory.
- Supports lw, sw, R-type, beq, addi, j.

---
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. It sequences
//   fetch / decode / execute / memory / writeback for lw, sw, R-type,
//   beq, addi and j, and drives every datapath mux select and enable.
//   Memory states use a ready handshake so the same controller works
//   with single-cycle SRAM or wait-stated memory.
//
// Parameters
//   MEM_WAIT_EN   1: FETCH/MEMRD/MEMWR hold until mem_ready=1.
//                 0: mem_ready is ignored and treated as 1.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   opcode[5:0]    instr[31:26] from IR, stable from DECODE onward
//   mem_ready      memory access completes this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero (beq)
//   iord           memory address select: 0=PC, 1=ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       IR load
//   mem_to_reg     register write data: 0=ALUOut, 1=MDR
//   reg_dst        write register: 0=rt, 1=rd
//   reg_write      register file write enable
//   alu_src_a      ALU A: 0=PC, 1=A register
//   alu_src_b[1:0] ALU B: 00=B, 01=4, 10=imm, 11=imm<<2
//   alu_op[1:0]    to alu_control: 00=add, 01=sub, 10=funct
//   pc_source[1:0] PC next: 00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op     unrecognised opcode seen in DECODE
//   state[3:0]     current state encoding, for debug
module multicycle_control #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       ready;

  // With waits disabled the memory is assumed to finish every access in
  // one cycle, whatever mem_ready says.
  assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // The debug view reads FETCH while reset is held, even before the
  // first reset edge has settled the register.
  assign state = reset_n ? state_q : FETCH;

  // Next-state and Moore-style output decode. Everything is forced to 0
  // while reset_n is low so no enable (in particular reg_write,
  // mem_write, pc_write, ir_write) can leak out during reset.
  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;

    if (reset_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          // IR and PC+4 are only committed on the cycle the read returns.
          ir_write  = ready;
          pc_write  = ready;
          state_d   = ready ? DECODE : FETCH;
        end
        DECODE: begin
          // Branch target is precomputed here into ALUOut.
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYP:      state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_ADDI:      state_d = ADDIEX;
            OP_J:         state_d = JUMP;
            default: begin
              state_d    = FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          state_d  = ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = FETCH;
        end
        MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          state_d   = ready ? FETCH : MEMWR;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = ALUWB;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = FETCH;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          state_d       = FETCH;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = ADDIWB;
        end
        ADDIWB: begin
          reg_write = 1'b1;
          state_d   = FETCH;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          state_d   = FETCH;
        end
        // Unused codes 12-15 drive nothing and recover to FETCH.
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
